// File: rtl/npc_trace_pkg.sv
// Shared types for the NPC difftest trace path.
//   XLEN / ILEN  : datapath and instruction widths
//   dt_state_e   : commit controller FSM states
//   commit_rec_t : one retired-instruction record as latched from writeback
package npc_trace_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_REPORT,
    ST_HALT,
    ST_HANG
  } dt_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
    logic            skip;
    logic            ebreak;
    logic [XLEN-1:0] a0;
  } commit_rec_t;

endpackage

// File: rtl/commit_watchdog.sv
// Idle-cycle watchdog for the difftest commit controller.
// Counts cycles in which the core could have committed but did not.
//   clock, reset : clock and asynchronous active-high reset
//   i_clear      : zero the counter (a commit was accepted)
//   i_count_en   : this cycle counts as idle
//   i_limit      : expiry threshold, 0 disables expiry
//   o_expire     : this idle cycle brings the count to the limit
// The caller decides what expiry means; this block only counts and compares.
module commit_watchdog #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         i_clear,
  input  logic         i_count_en,
  input  logic [W-1:0] i_limit,
  output logic         o_expire
);

  logic [W-1:0] r_count;
  logic [W-1:0] w_count_inc;

  // Saturate at all-ones so a huge limit can never be skipped by wrapping.
  assign w_count_inc = (&r_count) ? r_count : r_count + W'(1);

  // Compare against the value the counter is about to take, so the FSM can
  // leave IDLE on the very edge the idle count reaches the limit.
  assign o_expire = i_count_en && (i_limit != '0) && (w_count_inc >= i_limit);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_count_en) begin
      r_count <= w_count_inc;
    end
  end

endmodule

// File: rtl/difftest_commit_ctrl.sv
// Difftest commit sequencer for the NPC core.
// Takes one retired instruction at a time from writeback, lets it settle for
// SETTLE_CYCLES so register/CSR writes land, then offers it to the trace side
// with a valid/ready handshake. Counts reported commits, latches the halt
// code on ebreak and flags a hang when the core stops committing.
//   clock, reset        : clock and asynchronous active-high reset
//   commit_*            : writeback commit port (valid/ready + record)
//   trace_*             : trace/DPI port (valid/ready + latched record)
//   watchdog_limit      : idle-cycle limit, 0 disables the watchdog
//   inst_count          : reported commits, wraps modulo 2^64
//   halted / halt_ret   : sticky halt flag and a0 of the halting commit
//   hang                : sticky watchdog expiry
module difftest_commit_ctrl
  import npc_trace_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int TIMEOUT_W     = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 commit_valid,
  output logic                 commit_ready,
  input  logic [XLEN-1:0]      commit_pc,
  input  logic [ILEN-1:0]      commit_inst,
  input  logic                 commit_skip,
  input  logic                 commit_ebreak,
  input  logic [XLEN-1:0]      commit_a0,
  output logic                 trace_valid,
  input  logic                 trace_ready,
  output logic [XLEN-1:0]      trace_pc,
  output logic [ILEN-1:0]      trace_inst,
  output logic                 trace_skip,
  input  logic [TIMEOUT_W-1:0] watchdog_limit,
  output logic [XLEN-1:0]      inst_count,
  output logic                 halted,
  output logic [XLEN-1:0]      halt_ret,
  output logic                 hang
);

  // Settle counter runs SETTLE_CYCLES-1 down to 0; clamp so SETTLE_CYCLES=0
  // elaborates cleanly even though SETTLE is then never entered.
  localparam int         SETTLE_INIT = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_INIT);

  dt_state_e   r_state;
  commit_rec_t r_commit;
  logic [3:0]  r_settle_cnt;
  logic        w_accept;
  logic        w_wd_count_en;
  logic        w_expire;

  // Handshake flags decode the state register directly, so they are glitch
  // free and change only on clock edges.
  assign commit_ready  = (r_state == ST_IDLE);
  assign trace_valid   = (r_state == ST_REPORT);
  assign w_accept      = commit_valid && commit_ready;
  // Only an empty IDLE cycle is idle; a stalled trace consumer is not a hang.
  assign w_wd_count_en = (r_state == ST_IDLE) && !commit_valid;

  assign trace_pc   = r_commit.pc;
  assign trace_inst = r_commit.inst;
  assign trace_skip = r_commit.skip;

  commit_watchdog #(
    .W(TIMEOUT_W)
  ) u_watchdog (
    .clock     (clock),
    .reset     (reset),
    .i_clear   (w_accept),
    .i_count_en(w_wd_count_en),
    .i_limit   (watchdog_limit),
    .o_expire  (w_expire)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_commit     <= '0;
      r_settle_cnt <= '0;
      inst_count   <= '0;
      halted       <= 1'b0;
      halt_ret     <= '0;
      hang         <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // A commit in the expiry cycle wins: the core is evidently alive.
          if (w_accept) begin
            r_commit     <= '{pc: commit_pc, inst: commit_inst, skip: commit_skip,
                              ebreak: commit_ebreak, a0: commit_a0};
            r_settle_cnt <= SETTLE_LOAD;
            r_state      <= (SETTLE_CYCLES == 0) ? ST_REPORT : ST_SETTLE;
          end else if (w_expire) begin
            r_state <= ST_HANG;
            hang    <= 1'b1;
          end
        end
        ST_SETTLE: begin
          if (r_settle_cnt == 4'd0) begin
            r_state <= ST_REPORT;
          end else begin
            r_settle_cnt <= r_settle_cnt - 4'd1;
          end
        end
        ST_REPORT: begin
          if (trace_ready) begin
            inst_count <= inst_count + 64'd1;
            if (r_commit.ebreak) begin
              r_state  <= ST_HALT;
              halted   <= 1'b1;
              halt_ret <= r_commit.a0;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: begin
          // HALT and HANG hold until reset.
        end
      endcase
    end
  end

endmodule

// File: tb/tb_difftest_commit_ctrl.sv
module tb_difftest_commit_ctrl;
  import npc_trace_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  always #5 clock = ~clock;

  // Main DUT, default SETTLE_CYCLES=1
  logic        commit_valid, commit_ready, commit_skip, commit_ebreak;
  logic [63:0] commit_pc, commit_a0;
  logic [31:0] commit_inst;
  logic        trace_valid, trace_ready, trace_skip;
  logic [63:0] trace_pc;
  logic [31:0] trace_inst;
  logic [15:0] watchdog_limit;
  logic [63:0] inst_count, halt_ret;
  logic        halted, hang;

  // Second DUT, SETTLE_CYCLES=0
  logic        c0_commit_valid, c0_commit_ready, c0_trace_valid, c0_trace_skip;
  logic [63:0] c0_commit_pc, c0_trace_pc, c0_inst_count, c0_halt_ret;
  logic [31:0] c0_commit_inst, c0_trace_inst;
  logic        c0_halted, c0_hang;

  int n_checks = 0;
  int n_err    = 0;
  commit_rec_t sb_q[$];

  difftest_commit_ctrl dut (
    .clock(clock), .reset(reset),
    .commit_valid(commit_valid), .commit_ready(commit_ready),
    .commit_pc(commit_pc), .commit_inst(commit_inst), .commit_skip(commit_skip),
    .commit_ebreak(commit_ebreak), .commit_a0(commit_a0),
    .trace_valid(trace_valid), .trace_ready(trace_ready),
    .trace_pc(trace_pc), .trace_inst(trace_inst), .trace_skip(trace_skip),
    .watchdog_limit(watchdog_limit), .inst_count(inst_count),
    .halted(halted), .halt_ret(halt_ret), .hang(hang)
  );

  difftest_commit_ctrl #(.SETTLE_CYCLES(0)) dut0 (
    .clock(clock), .reset(reset),
    .commit_valid(c0_commit_valid), .commit_ready(c0_commit_ready),
    .commit_pc(c0_commit_pc), .commit_inst(c0_commit_inst), .commit_skip(1'b0),
    .commit_ebreak(1'b0), .commit_a0(64'd0),
    .trace_valid(c0_trace_valid), .trace_ready(1'b1),
    .trace_pc(c0_trace_pc), .trace_inst(c0_trace_inst), .trace_skip(c0_trace_skip),
    .watchdog_limit(16'd0), .inst_count(c0_inst_count),
    .halted(c0_halted), .halt_ret(c0_halt_ret), .hang(c0_hang)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every completed trace handshake must match the oldest expected record.
  always @(negedge clock) begin
    if (trace_valid === 1'b1 && trace_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_trace: got pc 0x%0h with no record expected", trace_pc);
      end else begin
        commit_rec_t e;
        e = sb_q.pop_front();
        check("sb_trace_pc", trace_pc, e.pc);
        check("sb_trace_inst", 64'(trace_inst), 64'(e.inst));
        check("sb_trace_skip", 64'(trace_skip), 64'(e.skip));
      end
    end
  end

  // Leaves the bench just after a rising edge, reset released.
  task automatic do_reset();
    reset        = 1'b1;
    commit_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [63:0] pc, input logic [31:0] inst, input logic skip,
                      input logic eb, input logic [63:0] a0, input bit expect_trace);
    bit acc;
    acc           = 1'b0;
    commit_valid  = 1'b1;
    commit_pc     = pc;
    commit_inst   = inst;
    commit_skip   = skip;
    commit_ebreak = eb;
    commit_a0     = a0;
    if (expect_trace) sb_q.push_back('{pc: pc, inst: inst, skip: skip, ebreak: eb, a0: a0});
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      acc = commit_ready;
      @(posedge clock);
      #1;
      if (acc) break;
    end
    commit_valid = 1'b0;
    if (!acc) check("send_accept_timeout", 64'(acc), 64'd1);
  endtask

  // Waits until the monitor has consumed every expected record.
  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (sb_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) check("drain_timeout", 64'(sb_q.size()), 64'd0);
    @(posedge clock);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1);
  end

  initial begin
    bit          seen, any_hang;
    int          n_acc, n_tr, bad, first_cyc, last_cyc;
    bit          acc0, prev_acc;
    logic [63:0] base;

    trace_ready     = 1'b0;
    watchdog_limit  = '0;
    commit_pc       = '0;
    commit_inst     = '0;
    commit_skip     = 1'b0;
    commit_ebreak   = 1'b0;
    commit_a0       = '0;
    c0_commit_valid = 1'b0;
    c0_commit_pc    = '0;
    c0_commit_inst  = 32'h0000_0013;

    // Reset state
    do_reset();
    @(negedge clock);
    check("rst_commit_ready", 64'(commit_ready), 64'd1);
    check("rst_trace_valid", 64'(trace_valid), 64'd0);
    check("rst_inst_count", inst_count, 64'd0);
    check("rst_halted", 64'(halted), 64'd0);
    check("rst_halt_ret", halt_ret, 64'd0);
    check("rst_hang", 64'(hang), 64'd0);
    check("rst_trace_pc", trace_pc, 64'd0);

    // Single commit with exact latency: accept t, trace t+2, ready again t+3
    @(posedge clock);
    #1;
    trace_ready   = 1'b1;
    commit_valid  = 1'b1;
    commit_pc     = 64'h0000_0000_8000_0000;
    commit_inst   = 32'h0000_0413;
    commit_skip   = 1'b0;
    commit_ebreak = 1'b0;
    sb_q.push_back('{pc: 64'h8000_0000, inst: 32'h0000_0413, skip: 1'b0, ebreak: 1'b0, a0: 64'd0});
    @(negedge clock);
    check("single_ready_t", 64'(commit_ready), 64'd1);
    @(posedge clock);
    #1 commit_valid = 1'b0;
    @(negedge clock);
    check("single_valid_t1", 64'(trace_valid), 64'd0);
    check("single_ready_t1", 64'(commit_ready), 64'd0);
    @(negedge clock);
    check("single_valid_t2", 64'(trace_valid), 64'd1);
    check("single_pc_t2", trace_pc, 64'h8000_0000);
    check("single_count_t2", inst_count, 64'd0);
    @(negedge clock);
    check("single_count_t3", inst_count, 64'd1);
    check("single_ready_t3", 64'(commit_ready), 64'd1);
    check("single_valid_t3", 64'(trace_valid), 64'd0);
    @(posedge clock);
    #1;

    // Back-pressure: 10 stalled REPORT cycles with watchdog_limit=4
    trace_ready    = 1'b0;
    watchdog_limit = 16'd4;
    send(64'h8000_0004, 32'h0010_0093, 1'b0, 1'b0, 64'd0, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (trace_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check("bp_valid_seen", 64'(seen), 64'd1);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clock);
      check("bp_trace_pc", trace_pc, 64'h8000_0004);
      check("bp_trace_inst", 64'(trace_inst), 64'h0010_0093);
      check("bp_trace_valid", 64'(trace_valid), 64'd1);
      check("bp_commit_ready", 64'(commit_ready), 64'd0);
      check("bp_hang", 64'(hang), 64'd0);
    end
    @(posedge clock);
    #1 trace_ready = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check("bp_after_ready", 64'(commit_ready), 64'd1);
    check("bp_after_count", inst_count, 64'd2);
    check("bp_after_hang1", 64'(hang), 64'd0);
    @(negedge clock);
    check("bp_after_hang2", 64'(hang), 64'd0);
    @(posedge clock);
    #1 watchdog_limit = '0;

    // Skip then ebreak with a0=0
    do_reset();
    send(64'h8000_0010, 32'h00a5_2023, 1'b1, 1'b0, 64'd0, 1'b1);
    wait_drain();
    send(64'h8000_0014, 32'h0010_0073, 1'b0, 1'b1, 64'd0, 1'b1);
    wait_drain();
    @(negedge clock);
    check("halt_halted", 64'(halted), 64'd1);
    check("halt_ret_zero", halt_ret, 64'd0);
    check("halt_count", inst_count, 64'd2);
    @(posedge clock);
    #1 commit_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("halt_commit_ready", 64'(commit_ready), 64'd0);
      check("halt_trace_valid", 64'(trace_valid), 64'd0);
    end
    @(posedge clock);
    #1 commit_valid = 1'b0;

    // ebreak with a nonzero halt code
    do_reset();
    send(64'h8000_0100, 32'h0010_0073, 1'b0, 1'b1, 64'h0000_0000_dead_beef, 1'b1);
    @(negedge clock);
    check("halt2_not_yet", 64'(halted), 64'd0);
    wait_drain();
    @(negedge clock);
    check("halt2_halted", 64'(halted), 64'd1);
    check("halt2_ret", halt_ret, 64'h0000_0000_dead_beef);
    check("halt2_count", inst_count, 64'd1);
    @(posedge clock);
    #1;

    // Watchdog limit 5, no commits: hang in cycle 6
    watchdog_limit = 16'd5;
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      @(negedge clock);
      check("wd_hang_early", 64'(hang), 64'd0);
    end
    @(negedge clock);
    check("wd_hang_c6", 64'(hang), 64'd1);
    check("wd_hang_ready", 64'(commit_ready), 64'd0);
    @(posedge clock);
    #1;

    // Commit arrives in the 5th idle cycle: accepted, no hang
    do_reset();
    repeat (4) @(posedge clock);
    #1;
    send(64'h8000_0200, 32'h0000_0013, 1'b0, 1'b0, 64'd0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("wd_race_hang", 64'(hang), 64'd0);
    end
    @(posedge clock);
    #1 watchdog_limit = '0;
    wait_drain();
    check("wd_race_count", inst_count, 64'd1);

    // Limit 0 disables the watchdog
    do_reset();
    any_hang = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clock);
      if (hang) any_hang = 1'b1;
    end
    check("wd_disabled", 64'(any_hang), 64'd0);
    @(posedge clock);
    #1;

    // Reset while the commit is settling: no trace for it
    do_reset();
    send(64'h8000_0300, 32'h0000_0013, 1'b0, 1'b0, 64'd0, 1'b0);
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (trace_valid) seen = 1'b1;
    end
    check("mid_rst_no_trace", 64'(seen), 64'd0);
    check("mid_rst_count", inst_count, 64'd0);
    check("mid_rst_ready", 64'(commit_ready), 64'd1);
    @(posedge clock);
    #1;

    // SETTLE_CYCLES=0: trace the cycle after acceptance, one commit per 2 cycles
    base            = 64'h8000_1000;
    n_acc           = 0;
    n_tr            = 0;
    bad             = 0;
    first_cyc       = 0;
    last_cyc        = 0;
    prev_acc        = 1'b0;
    c0_commit_pc    = base;
    c0_commit_valid = 1'b1;
    for (int cyc = 0; cyc < 400 && n_tr < 100; cyc++) begin
      @(negedge clock);
      acc0 = c0_commit_valid && c0_commit_ready;
      if (c0_trace_valid) begin
        if (!prev_acc) bad++;
        if (c0_trace_pc !== base + 64'(4 * n_tr)) bad++;
        if (c0_trace_inst !== 32'h0000_0013) bad++;
        n_tr++;
      end
      if (acc0) begin
        if (n_acc == 0) first_cyc = cyc;
        last_cyc = cyc;
        n_acc++;
      end
      prev_acc = acc0;
      @(posedge clock);
      #1;
      if (acc0) begin
        if (n_acc == 100) c0_commit_valid = 1'b0;
        else c0_commit_pc = base + 64'(4 * n_acc);
      end
    end
    check("s0_timing_errors", 64'(bad), 64'd0);
    check("s0_traces", 64'(n_tr), 64'd100);
    check("s0_accept_span", 64'(last_cyc - first_cyc), 64'd198);
    @(negedge clock);
    check("s0_inst_count", c0_inst_count, 64'd100);
    check("s0_ready", 64'(c0_commit_ready), 64'd1);
    check("s0_flags", {61'd0, c0_halted, c0_hang, c0_trace_skip}, 64'd0);
    check("s0_halt_ret", c0_halt_ret, 64'd0);

    check("sb_empty_at_end", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
